// File: rtl/xaddrgen_sched.sv
// xaddrgen_sched: descriptor FIFO plus launch FSM for a single xaddrgen.
// Each queued job is loaded into the ag_* configuration registers. The FSM then
// pulses init/run and waits for done to fall and rise again.
// Optional feature: define XADDRGEN_SCHED_PERF_EN to build the busy_cycles
// counter. When it is undefined, busy_cycles is tied to 0.
module xaddrgen_sched #(
   parameter int MEM_ADDR_W = 10,
   parameter int PERIOD_W   = 10,
   parameter int QDEPTH_W   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sched_en,
   input  logic                         flush,
   input  logic                         pause_in,
   input  logic                         desc_valid,
   output logic                         desc_ready,
   input  logic        [MEM_ADDR_W-1:0] desc_iter,
   input  logic        [PERIOD_W-1:0]   desc_per,
   input  logic        [PERIOD_W-1:0]   desc_duty,
   input  logic        [PERIOD_W-1:0]   desc_delay,
   input  logic        [MEM_ADDR_W-1:0] desc_start,
   input  logic signed [MEM_ADDR_W-1:0] desc_shift,
   input  logic signed [MEM_ADDR_W-1:0] desc_incr,
   output logic        [MEM_ADDR_W-1:0] ag_iterations,
   output logic        [PERIOD_W-1:0]   ag_period,
   output logic        [PERIOD_W-1:0]   ag_duty,
   output logic        [PERIOD_W-1:0]   ag_delay,
   output logic        [MEM_ADDR_W-1:0] ag_start,
   output logic signed [MEM_ADDR_W-1:0] ag_shift,
   output logic signed [MEM_ADDR_W-1:0] ag_incr,
   output logic                         ag_init,
   output logic                         ag_run,
   output logic                         ag_pause,
   input  logic                         ag_done,
   output logic                         busy,
   output logic                         job_done,
   output logic [15:0]                  jobs_cnt,
   output logic [QDEPTH_W:0]            q_level,
   output logic [31:0]                  busy_cycles
);

   localparam int DEPTH = 1 << QDEPTH_W;
   localparam int DW    = 4 * MEM_ADDR_W + 3 * PERIOD_W;
   localparam logic [QDEPTH_W:0] FULL_LVL = (QDEPTH_W + 1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, INIT, RUN, ARM, WAIT} state_t;

   state_t              state, state_next;
   logic [DW-1:0]       mem [DEPTH];
   logic [DW-1:0]       cfg;
   logic [QDEPTH_W-1:0] wr_ptr, rd_ptr;
   logic [QDEPTH_W:0]   level_next;
   logic                push, pop, launch, finish;

   // A push during flush is dropped. A pop happens only while loading a job.
   assign push   = desc_valid && desc_ready && !flush;
   assign pop    = (state == LOAD);
   // Counting the same-cycle push lets a job pushed into an empty queue load next cycle.
   assign launch = sched_en && !flush && ((q_level != '0) || push);
   assign finish = (state == WAIT) && ag_done;
   assign busy     = (state != IDLE);
   assign ag_pause = pause_in;

   assign {ag_iterations, ag_period, ag_duty, ag_delay, ag_start, ag_shift, ag_incr} = cfg;

   // Queue occupancy after this cycle's flush, push and pop.
   always_comb begin
      level_next = q_level;
      if (flush) begin
         level_next = '0;
      end else if (push && !pop) begin
         level_next = q_level + 1'b1;
      end else if (pop && !push) begin
         level_next = q_level - 1'b1;
      end
   end

   // Descriptor storage (data only, not reset).
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {desc_iter, desc_per, desc_duty, desc_delay,
                         desc_start, desc_shift, desc_incr};
      end
   end

   // Queue pointers, occupancy and registered ready flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         q_level    <= '0;
         desc_ready <= 1'b1;
      end else begin
         q_level    <= level_next;
         desc_ready <= (level_next != FULL_LVL);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Job sequencing: load, init pulse, run pulse, then the done fall/rise handshake.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (launch) state_next = LOAD;
         LOAD:    state_next = INIT;
         INIT:    state_next = RUN;
         RUN:     state_next = ARM;
         ARM:     if (!ag_done) state_next = WAIT;
         WAIT:    if (ag_done) state_next = launch ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register and registered one-cycle pulses and job counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ag_init  <= 1'b0;
         ag_run   <= 1'b0;
         job_done <= 1'b0;
         jobs_cnt <= '0;
      end else begin
         state    <= state_next;
         ag_init  <= (state_next == INIT);
         ag_run   <= (state_next == RUN);
         job_done <= finish;
         if (finish) jobs_cnt <= jobs_cnt + 16'd1;
      end
   end

   // Configuration is captured from the queue head in LOAD and held for the whole job.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg <= '0;
      end else if (pop) begin
         cfg <= mem[rd_ptr];
      end
   end

`ifdef XADDRGEN_SCHED_PERF_EN
   // Saturating count of cycles spent outside IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_cycles <= '0;
      end else if (busy && (busy_cycles != '1)) begin
         busy_cycles <= busy_cycles + 32'd1;
      end
   end
`else
   assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_xaddrgen_sched.sv
// Testbench for xaddrgen_sched. It includes a small generator model that drops
// done after run and raises it again GEN_LEN+1 cycles later. A negedge monitor
// records config at init plus pulse timing. Expected descriptors go through a
// scoreboard queue.
`timescale 1ns/1ps
module tb_xaddrgen_sched;

   localparam int AW = 10;
   localparam int PW = 10;
   localparam int QW = 2;
   localparam int GEN_LEN = 5;

   typedef struct packed {
      logic [AW-1:0] iter;
      logic [PW-1:0] per;
      logic [PW-1:0] duty;
      logic [PW-1:0] delay;
      logic [AW-1:0] start;
      logic [AW-1:0] shift;
      logic [AW-1:0] incr;
   } desc_t;

   logic clk = 1'b0, rst = 1'b0, sched_en = 1'b0, flush = 1'b0, pause_in = 1'b0;
   logic desc_valid = 1'b0;
   logic [AW-1:0] desc_iter = '0, desc_start = '0, desc_shift = '0, desc_incr = '0;
   logic [PW-1:0] desc_per = '0, desc_duty = '0, desc_delay = '0;
   logic [AW-1:0] ag_iterations, ag_start, ag_shift, ag_incr;
   logic [PW-1:0] ag_period, ag_duty, ag_delay;
   logic ag_init, ag_run, ag_pause, busy, job_done, desc_ready;
   logic [15:0] jobs_cnt;
   logic [QW:0] q_level;
   logic [31:0] busy_cycles;

   int checks = 0, errors = 0, exp_jobs = 0, act_rd = 0, cyc = 0;
   desc_t exp_q[$];
   desc_t act_q[$];
   int init_cyc[$], run_cyc[$], rise_cyc[$], jd_cyc[$];

`ifdef XADDRGEN_SCHED_PERF_EN
   localparam int PERF_EXP = 40;
`else
   localparam int PERF_EXP = 0;
`endif

   xaddrgen_sched #(.MEM_ADDR_W(AW), .PERIOD_W(PW), .QDEPTH_W(QW)) dut (
      .clk(clk), .rst(rst), .sched_en(sched_en), .flush(flush), .pause_in(pause_in),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_iter(desc_iter),
      .desc_per(desc_per), .desc_duty(desc_duty), .desc_delay(desc_delay),
      .desc_start(desc_start), .desc_shift(desc_shift), .desc_incr(desc_incr),
      .ag_iterations(ag_iterations), .ag_period(ag_period), .ag_duty(ag_duty),
      .ag_delay(ag_delay), .ag_start(ag_start), .ag_shift(ag_shift), .ag_incr(ag_incr),
      .ag_init(ag_init), .ag_run(ag_run), .ag_pause(ag_pause), .ag_done(gen_done),
      .busy(busy), .job_done(job_done), .jobs_cnt(jobs_cnt), .q_level(q_level),
      .busy_cycles(busy_cycles)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Generator model: done idles high, falls after run, rises GEN_LEN+1 cycles later.
   logic gen_done = 1'b1;
   int gen_cnt = 0;
   always @(posedge clk) begin
      if (ag_run) begin
         gen_done <= 1'b0;
         gen_cnt  <= GEN_LEN;
      end else if (!gen_done) begin
         if (gen_cnt == 0) gen_done <= 1'b1;
         else gen_cnt <= gen_cnt - 1;
      end
   end

   // Monitor: record config at each init pulse and the cycle of each event.
   logic prev_done = 1'b1;
   always @(negedge clk) begin
      if (ag_init) begin
         act_q.push_back({ag_iterations, ag_period, ag_duty, ag_delay, ag_start, ag_shift, ag_incr});
         init_cyc.push_back(cyc);
      end
      if (ag_run) run_cyc.push_back(cyc);
      if (gen_done && !prev_done) rise_cyc.push_back(cyc);
      if (job_done) jd_cyc.push_back(cyc);
      prev_done <= gen_done;
   end

   function automatic desc_t mk(input int id);
      desc_t d;
      d.iter  = AW'(4 + id);
      d.per   = PW'(2 + id % 3);
      d.duty  = PW'(1 + id % 2);
      d.delay = PW'(id);
      d.start = AW'(16 * id + 5);
      d.shift = AW'(-id);
      d.incr  = AW'(1 + id);
      return d;
   endfunction

   task automatic push_desc(input desc_t d, input bit acc);
      desc_valid = 1'b1;
      desc_iter  = d.iter;  desc_per   = d.per;   desc_duty = d.duty;
      desc_delay = d.delay; desc_start = d.start; desc_shift = d.shift;
      desc_incr  = d.incr;
      @(negedge clk);
      desc_valid = 1'b0;
      if (acc) exp_q.push_back(d);
   endtask

   task automatic wait_jobs(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (jd_cyc.size() >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_run(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (ag_run === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({ag_init, ag_run, busy, job_done, desc_ready} !== 5'b00001) begin
         errors++;
         $display("FAIL reset_ctrl: init/run/busy/jd/ready got %b want 00001",
                  {ag_init, ag_run, busy, job_done, desc_ready});
      end
      checks++;
      if (jobs_cnt !== 16'd0 || q_level !== 3'd0) begin
         errors++;
         $display("FAIL reset_cnt: jobs_cnt=%0d q_level=%0d want 0 0", jobs_cnt, q_level);
      end
      checks++;
      if ({ag_iterations, ag_period, ag_duty, ag_delay, ag_start, ag_shift, ag_incr} !== 70'd0) begin
         errors++;
         $display("FAIL reset_cfg: got %h want 0",
                  {ag_iterations, ag_period, ag_duty, ag_delay, ag_start, ag_shift, ag_incr});
      end
      checks++;
      if (busy_cycles !== 32'd0) begin
         errors++;
         $display("FAIL reset_perf: busy_cycles got %0d want 0", busy_cycles);
      end
      rst = 1'b1;
      exp_jobs = 0;
      @(negedge clk);
   endtask

   task automatic test_single();
      desc_t d, a, e;
      int t, n0, r0, j0, got;
      bit ok;
      d = '0;
      d.iter = 10'd4; d.per = 10'd2; d.duty = 10'd2; d.start = 10'h10; d.incr = 10'd1;
      n0 = init_cyc.size(); r0 = run_cyc.size(); j0 = jd_cyc.size();
      pause_in = 1'b1;
      #1;
      checks++;
      if (ag_pause !== 1'b1) begin errors++; $display("FAIL pause_hi: got %b want 1", ag_pause); end
      pause_in = 1'b0;
      #1;
      checks++;
      if (ag_pause !== 1'b0) begin errors++; $display("FAIL pause_lo: got %b want 0", ag_pause); end
      @(negedge clk);
      sched_en = 1'b1;
      t = cyc;
      push_desc(d, 1'b1);
      wait_jobs(j0 + 1, 60, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout: job_done got none want 1"); end
      repeat (3) @(negedge clk);
      exp_jobs++;
      got = (init_cyc.size() > n0) ? init_cyc[n0] : -1;
      checks++;
      if (got !== t + 2) begin errors++; $display("FAIL single_init_lat: cycle %0d want %0d", got, t + 2); end
      got = (run_cyc.size() > r0) ? run_cyc[r0] : -1;
      checks++;
      if (got !== t + 3) begin errors++; $display("FAIL single_run_lat: cycle %0d want %0d", got, t + 3); end
      checks++;
      if (act_rd >= act_q.size() || exp_q.size() == 0) begin
         errors++; $display("FAIL single_sb: missing job");
      end else begin
         e = exp_q.pop_front(); a = act_q[act_rd]; act_rd++;
         if (a !== e) begin errors++; $display("FAIL single_sb: cfg got %h want %h", a, e); end
      end
      checks++;
      if (jd_cyc.size() - j0 !== 1 || jobs_cnt !== 16'(exp_jobs)) begin
         errors++;
         $display("FAIL single_done: pulses=%0d jobs_cnt=%0d want 1 %0d", jd_cyc.size() - j0, jobs_cnt, exp_jobs);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b want 0", busy); end
   endtask

   task automatic test_fill();
      desc_t a, e;
      int j0;
      bit ok;
      j0 = jd_cyc.size();
      sched_en = 1'b0;
      for (int i = 0; i < 4; i++) push_desc(mk(i), 1'b1);
      checks++;
      if (desc_ready !== 1'b0 || q_level !== 3'd4) begin
         errors++; $display("FAIL fill_full: ready=%b level=%0d want 0 4", desc_ready, q_level);
      end
      push_desc(mk(4), 1'b0);
      checks++;
      if (desc_ready !== 1'b0 || q_level !== 3'd4) begin
         errors++; $display("FAIL fill_ignored: ready=%b level=%0d want 0 4", desc_ready, q_level);
      end
      sched_en = 1'b1;
      wait_jobs(j0 + 4, 200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL fill_timeout: pulses got %0d want 4", jd_cyc.size() - j0); end
      repeat (20) @(negedge clk);
      exp_jobs += 4;
      checks++;
      if (jd_cyc.size() - j0 !== 4 || q_level !== 3'd0 || jobs_cnt !== 16'(exp_jobs)) begin
         errors++;
         $display("FAIL fill_count: pulses=%0d level=%0d jobs_cnt=%0d want 4 0 %0d",
                  jd_cyc.size() - j0, q_level, jobs_cnt, exp_jobs);
      end
      repeat (4) begin
         checks++;
         if (act_rd >= act_q.size() || exp_q.size() == 0) begin
            errors++; $display("FAIL fill_sb: missing job");
         end else begin
            e = exp_q.pop_front(); a = act_q[act_rd]; act_rd++;
            if (a !== e) begin errors++; $display("FAIL fill_sb: cfg got %h want %h", a, e); end
         end
      end
   endtask

   task automatic test_sched_en();
      desc_t a, e;
      int j0, n0;
      bit ok;
      j0 = jd_cyc.size(); n0 = init_cyc.size();
      sched_en = 1'b0;
      push_desc(mk(10), 1'b1);
      push_desc(mk(11), 1'b1);
      repeat (6) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || q_level !== 3'd2 || init_cyc.size() !== n0) begin
         errors++;
         $display("FAIL en_hold: busy=%b level=%0d inits=%0d want 0 2 0", busy, q_level, init_cyc.size() - n0);
      end
      sched_en = 1'b1;
      wait_jobs(j0 + 2, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL en_timeout: pulses got %0d want 2", jd_cyc.size() - j0); end
      repeat (3) @(negedge clk);
      exp_jobs += 2;
      repeat (2) begin
         checks++;
         if (act_rd >= act_q.size() || exp_q.size() == 0) begin
            errors++; $display("FAIL en_sb: missing job");
         end else begin
            e = exp_q.pop_front(); a = act_q[act_rd]; act_rd++;
            if (a !== e) begin errors++; $display("FAIL en_sb: cfg got %h want %h", a, e); end
         end
      end
   endtask

   task automatic test_back_to_back();
      desc_t a, e;
      int j0, r0, rise, got;
      bit ok;
      j0 = jd_cyc.size(); r0 = run_cyc.size();
      sched_en = 1'b0;
      push_desc(mk(12), 1'b1);
      push_desc(mk(13), 1'b1);
      sched_en = 1'b1;
      wait_jobs(j0 + 2, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_timeout: pulses got %0d want 2", jd_cyc.size() - j0); end
      repeat (3) @(negedge clk);
      exp_jobs += 2;
      rise = -100;
      foreach (rise_cyc[i]) begin
         if (rise < 0 && run_cyc.size() > r0 && rise_cyc[i] > run_cyc[r0]) rise = rise_cyc[i];
      end
      got = (run_cyc.size() > r0 + 1) ? run_cyc[r0 + 1] - rise : -1;
      checks++;
      if (got !== 3) begin errors++; $display("FAIL b2b_run_gap: cycles %0d want 3", got); end
      got = (jd_cyc.size() > j0) ? jd_cyc[j0] - rise : -1;
      checks++;
      if (got !== 1) begin errors++; $display("FAIL b2b_jd_gap: cycles %0d want 1", got); end
      repeat (2) begin
         checks++;
         if (act_rd >= act_q.size() || exp_q.size() == 0) begin
            errors++; $display("FAIL b2b_sb: missing job");
         end else begin
            e = exp_q.pop_front(); a = act_q[act_rd]; act_rd++;
            if (a !== e) begin errors++; $display("FAIL b2b_sb: cfg got %h want %h", a, e); end
         end
      end
   endtask

   task automatic test_flush();
      desc_t a, e;
      int j0, n0;
      bit ok;
      j0 = jd_cyc.size(); n0 = init_cyc.size();
      sched_en = 1'b0;
      for (int i = 20; i < 24; i++) push_desc(mk(i), 1'b1);
      sched_en = 1'b1;
      wait_run(40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL flush_run_timeout: ag_run got 0 want 1"); end
      repeat (2) @(negedge clk);
      checks++;
      if (q_level !== 3'd3 || busy !== 1'b1) begin
         errors++; $display("FAIL flush_pre: level=%0d busy=%b want 3 1", q_level, busy);
      end
      flush = 1'b1;
      push_desc(mk(99), 1'b0);
      flush = 1'b0;
      repeat (3) void'(exp_q.pop_back());
      wait_jobs(j0 + 1, 60, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL flush_timeout: pulses got 0 want 1"); end
      repeat (6) @(negedge clk);
      exp_jobs++;
      checks++;
      if (q_level !== 3'd0 || busy !== 1'b0 || jobs_cnt !== 16'(exp_jobs)) begin
         errors++;
         $display("FAIL flush_end: level=%0d busy=%b jobs_cnt=%0d want 0 0 %0d", q_level, busy, jobs_cnt, exp_jobs);
      end
      checks++;
      if (init_cyc.size() - n0 !== 1 || jd_cyc.size() - j0 !== 1) begin
         errors++;
         $display("FAIL flush_jobs: inits=%0d pulses=%0d want 1 1", init_cyc.size() - n0, jd_cyc.size() - j0);
      end
      checks++;
      if (act_rd >= act_q.size() || exp_q.size() == 0) begin
         errors++; $display("FAIL flush_sb: missing job");
      end else begin
         e = exp_q.pop_front(); a = act_q[act_rd]; act_rd++;
         if (a !== e) begin errors++; $display("FAIL flush_sb: cfg got %h want %h", a, e); end
      end
   endtask

   task automatic test_reset_mid_and_perf();
      desc_t a, e;
      int j0;
      bit ok;
      sched_en = 1'b0;
      push_desc(mk(30), 1'b1);
      push_desc(mk(31), 1'b0);
      sched_en = 1'b1;
      wait_run(40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rmid_run_timeout: ag_run got 0 want 1"); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      exp_jobs = 0;
      checks++;
      if ({ag_init, ag_run, busy, job_done, desc_ready} !== 5'b00001) begin
         errors++;
         $display("FAIL rmid_ctrl: init/run/busy/jd/ready got %b want 00001",
                  {ag_init, ag_run, busy, job_done, desc_ready});
      end
      checks++;
      if (jobs_cnt !== 16'd0 || q_level !== 3'd0 || busy_cycles !== 32'd0) begin
         errors++;
         $display("FAIL rmid_cnt: jobs_cnt=%0d level=%0d busy_cycles=%0d want 0 0 0", jobs_cnt, q_level, busy_cycles);
      end
      checks++;
      if ({ag_iterations, ag_period, ag_duty, ag_delay, ag_start, ag_shift, ag_incr} !== 70'd0) begin
         errors++;
         $display("FAIL rmid_cfg: got %h want 0",
                  {ag_iterations, ag_period, ag_duty, ag_delay, ag_start, ag_shift, ag_incr});
      end
      checks++;
      if (act_rd >= act_q.size() || exp_q.size() == 0) begin
         errors++; $display("FAIL rmid_sb: missing job");
      end else begin
         e = exp_q.pop_front(); a = act_q[act_rd]; act_rd++;
         if (a !== e) begin errors++; $display("FAIL rmid_sb: cfg got %h want %h", a, e); end
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 20 && !gen_done; i++) @(negedge clk);
      @(negedge clk);
      j0 = jd_cyc.size();
      sched_en = 1'b0;
      for (int i = 40; i < 44; i++) push_desc(mk(i), 1'b1);
      sched_en = 1'b1;
      wait_jobs(j0 + 4, 200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL perf_timeout: pulses got %0d want 4", jd_cyc.size() - j0); end
      repeat (4) @(negedge clk);
      exp_jobs += 4;
      checks++;
      if (busy_cycles !== 32'(PERF_EXP)) begin
         errors++; $display("FAIL perf_busy_cycles: got %0d want %0d", busy_cycles, PERF_EXP);
      end
      checks++;
      if (jobs_cnt !== 16'(exp_jobs)) begin
         errors++; $display("FAIL perf_jobs: jobs_cnt got %0d want %0d", jobs_cnt, exp_jobs);
      end
      repeat (4) begin
         checks++;
         if (act_rd >= act_q.size() || exp_q.size() == 0) begin
            errors++; $display("FAIL perf_sb: missing job");
         end else begin
            e = exp_q.pop_front(); a = act_q[act_rd]; act_rd++;
            if (a !== e) begin errors++; $display("FAIL perf_sb: cfg got %h want %h", a, e); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_sched_en();
      test_back_to_back();
      test_flush();
      test_reset_mid_and_perf();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
